// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the accumulator sequencer and its neighbours.
//   - acc_state_t   : sequencer FSM states
//   - FP32_POS_ZERO : +0.0 encoding, the accumulator's cleared value
//   - FP32_QNAN     : canonical quiet NaN returned by the adder
//   - EXP_W / MAN_W : FP32 field widths
//   - fp32_is_zero  : true for +0 or -0
package fp32_pkg;

    typedef enum logic [2:0] {
        GET_X   = 3'd0,
        SEND_A  = 3'd1,
        SEND_B  = 3'd2,
        WAIT_Z  = 3'd3,
        PUT_SUM = 3'd4
    } acc_state_t;

    localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_QNAN     = 32'hFFC0_0000;
    localparam int          EXP_W         = 8;
    localparam int          MAN_W         = 23;

    // Magnitude-only test so both signed zeros match.
    function automatic logic fp32_is_zero(input logic [31:0] v);
        return v[EXP_W+MAN_W-1:0] == '0;
    endfunction

endpackage

// File: rtl/fp32_acc_seq.sv
// fp32_acc_seq: sequences an external FP32 adder to sum VEC_LEN input
// elements, then presents the sum on a stb/ack port.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_data/in_stb/in_ack          element stream (consumer side)
//   add_a/add_a_stb/add_a_ack      adder operand A (accumulator)
//   add_b/add_b_stb/add_b_ack      adder operand B (element)
//   add_z/add_z_stb/add_z_ack      adder result
//   sum_data/sum_stb/sum_ack       final sum (producer side)
//   busy                           low only when idle in GET_X with count 0
//
// Optional build macro FP32_ACC_SKIP_ZERO_EN: a zero element arriving while
// the accumulator is non-zero bypasses the adder (acc is unchanged).
module fp32_acc_seq
    import fp32_pkg::*;
#(
    parameter  int VEC_LEN = 8,
    localparam int CNT_W   = $clog2(VEC_LEN + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_stb,
    output logic        in_ack,
    output logic [31:0] add_a,
    output logic        add_a_stb,
    input  logic        add_a_ack,
    output logic [31:0] add_b,
    output logic        add_b_stb,
    input  logic        add_b_ack,
    input  logic [31:0] add_z,
    input  logic        add_z_stb,
    output logic        add_z_ack,
    output logic [31:0] sum_data,
    output logic        sum_stb,
    input  logic        sum_ack,
    output logic        busy
);

    acc_state_t       r_state;
    logic [31:0]      r_acc;
    logic [31:0]      r_x;
    logic [CNT_W-1:0] r_count;
    logic             r_in_ack;
    logic [31:0]      r_add_a;
    logic             r_add_a_stb;
    logic [31:0]      r_add_b;
    logic             r_add_b_stb;
    logic             r_add_z_ack;
    logic [31:0]      r_sum_data;
    logic             r_sum_stb;

    // The element being retired now is the last one of the vector.
    logic w_last;
    assign w_last = (int'(r_count) + 1) == VEC_LEN;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= GET_X;
            r_acc       <= FP32_POS_ZERO;
            r_x         <= '0;
            r_count     <= '0;
            r_in_ack    <= 1'b0;
            r_add_a     <= '0;
            r_add_a_stb <= 1'b0;
            r_add_b     <= '0;
            r_add_b_stb <= 1'b0;
            r_add_z_ack <= 1'b0;
            r_sum_data  <= '0;
            r_sum_stb   <= 1'b0;
        end else begin
            case (r_state)
                GET_X: begin
                    r_in_ack <= 1'b1;
                    if (in_stb && r_in_ack) begin
                        r_in_ack <= 1'b0;
                        r_x      <= in_data;
`ifdef FP32_ACC_SKIP_ZERO_EN
                        // acc==±0 still goes through the adder so the
                        // adder decides the sign of a zero result.
                        if (fp32_is_zero(in_data) && !fp32_is_zero(r_acc)) begin
                            r_count <= r_count + 1'b1;
                            r_state <= w_last ? PUT_SUM : GET_X;
                        end else begin
                            r_state <= SEND_A;
                        end
`else
                        r_state <= SEND_A;
`endif
                    end
                end
                SEND_A: begin
                    r_add_a     <= r_acc;
                    r_add_a_stb <= 1'b1;
                    if (r_add_a_stb && add_a_ack) begin
                        r_add_a_stb <= 1'b0;
                        r_state     <= SEND_B;
                    end
                end
                SEND_B: begin
                    r_add_b     <= r_x;
                    r_add_b_stb <= 1'b1;
                    if (r_add_b_stb && add_b_ack) begin
                        r_add_b_stb <= 1'b0;
                        r_state     <= WAIT_Z;
                    end
                end
                WAIT_Z: begin
                    r_add_z_ack <= 1'b1;
                    if (add_z_stb && r_add_z_ack) begin
                        r_acc       <= add_z;
                        r_add_z_ack <= 1'b0;
                        r_count     <= r_count + 1'b1;
                        r_state     <= w_last ? PUT_SUM : GET_X;
                    end
                end
                PUT_SUM: begin
                    // in_ack is already low here, so a stalled sum_ack
                    // holds off the next vector's first element.
                    r_sum_data <= r_acc;
                    r_sum_stb  <= 1'b1;
                    if (r_sum_stb && sum_ack) begin
                        r_sum_stb <= 1'b0;
                        r_acc     <= FP32_POS_ZERO;
                        r_count   <= '0;
                        r_state   <= GET_X;
                    end
                end
                default: r_state <= GET_X;
            endcase
        end
    end

    assign in_ack    = r_in_ack;
    assign add_a     = r_add_a;
    assign add_a_stb = r_add_a_stb;
    assign add_b     = r_add_b;
    assign add_b_stb = r_add_b_stb;
    assign add_z_ack = r_add_z_ack;
    assign sum_data  = r_sum_data;
    assign sum_stb   = r_sum_stb;
    assign busy      = (r_state != GET_X) || (r_count != '0);

endmodule

// File: tb/tb_fp32_acc_seq.sv
module tb_fp32_acc_seq;

    localparam int VL = 4;
`ifdef FP32_ACC_SKIP_ZERO_EN
    localparam int SKIP = 1;
`else
    localparam int SKIP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_stb = 1'b0;
    logic        in_ack;
    logic [31:0] add_a, add_b, add_z;
    logic        add_a_stb, add_a_ack, add_b_stb, add_b_ack, add_z_stb, add_z_ack;
    logic [31:0] sum_data;
    logic        sum_stb, busy;
    logic        sum_ack = 1'b0;

    always #5 clk = ~clk;

    fp32_acc_seq #(.VEC_LEN(VL)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_stb(in_stb), .in_ack(in_ack),
        .add_a(add_a), .add_a_stb(add_a_stb), .add_a_ack(add_a_ack),
        .add_b(add_b), .add_b_stb(add_b_stb), .add_b_ack(add_b_ack),
        .add_z(add_z), .add_z_stb(add_z_stb), .add_z_ack(add_z_ack),
        .sum_data(sum_data), .sum_stb(sum_stb), .sum_ack(sum_ack),
        .busy(busy)
    );

    // ---------------- FP32 helpers (via IEEE double) ----------------
    function automatic logic [63:0] f2d(input logic [31:0] f);
        int e;
        if (f[30:23] == 8'h00) return {f[31], 63'b0};
        if (f[30:23] == 8'hFF)
            return (f[22:0] != 0) ? {1'b0, 11'h7FF, 1'b1, 51'b0} : {f[31], 11'h7FF, 52'b0};
        e = int'(f[30:23]) - 127 + 1023;
        return {f[31], e[10:0], f[22:0], 29'b0};
    endfunction

    function automatic logic [31:0] d2f(input logic [63:0] d);
        int e;
        if (d[62:52] == 11'h000) return {d[63], 31'b0};
        if (d[62:52] == 11'h7FF)
            return (d[51:0] != 0) ? 32'hFFC00000 : {d[63], 8'hFF, 23'b0};
        e = int'(d[62:52]) - 1023 + 127;
        if (e >= 255) return {d[63], 8'hFF, 23'b0};
        if (e <= 0)   return {d[63], 31'b0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic is_nan(input logic [31:0] f);
        return f[30:23] == 8'hFF && f[22:0] != 0;
    endfunction

    function automatic logic is_inf(input logic [31:0] f);
        return f[30:23] == 8'hFF && f[22:0] == 0;
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        if (is_nan(a) || is_nan(b)) return 32'hFFC00000;
        if (is_inf(a) && is_inf(b) && a[31] != b[31]) return 32'hFFC00000;
        if (is_inf(a)) return a;
        if (is_inf(b)) return b;
        return d2f($realtobits($bitstoreal(f2d(a)) + $bitstoreal(f2d(b))));
    endfunction

    function automatic logic [31:0] int2f(input int v);
        return d2f($realtobits(real'(v)));
    endfunction

    // ---------------- Adder model: A then B, random latency ----------------
    logic [1:0]  ad_st;
    logic [31:0] ad_a;
    int          ad_lat;
    always @(posedge clk) begin
        if (rst) begin
            ad_st <= 0; add_a_ack <= 0; add_b_ack <= 0; add_z_stb <= 0; add_z <= 0;
        end else begin
            case (ad_st)
                2'd0: begin
                    add_a_ack <= 1;
                    if (add_a_stb && add_a_ack) begin add_a_ack <= 0; ad_a <= add_a; ad_st <= 2'd1; end
                end
                2'd1: begin
                    add_b_ack <= 1;
                    if (add_b_stb && add_b_ack) begin
                        add_b_ack <= 0; add_z <= fadd(ad_a, add_b);
                        ad_lat <= int'($urandom_range(0, 2)); ad_st <= 2'd2;
                    end
                end
                2'd2: if (ad_lat == 0) begin add_z_stb <= 1; ad_st <= 2'd3; end
                      else ad_lat <= ad_lat - 1;
                default: if (add_z_stb && add_z_ack) begin add_z_stb <= 0; ad_st <= 2'd0; end
            endcase
        end
    end

    // ---------------- Protocol monitor and transfer counters ----------------
    int          a_xfers = 0, z_xfers = 0, proto_bad = 0;
    logic        p_rst = 1'b1, p_a_stb = 0, p_a_ack = 0, p_b_stb = 0, p_b_ack = 0;
    logic        p_s_stb = 0, p_s_ack = 0, a_done = 0;
    logic [31:0] p_a = 0, p_b = 0, p_s = 0;
    always @(posedge clk) begin
        if (!p_rst && !rst) begin
            if (p_a_stb && !p_a_ack && (!add_a_stb || add_a != p_a)) proto_bad <= proto_bad + 1;
            if (p_b_stb && !p_b_ack && (!add_b_stb || add_b != p_b)) proto_bad <= proto_bad + 1;
            if (p_s_stb && !p_s_ack && (!sum_stb || sum_data != p_s)) proto_bad <= proto_bad + 1;
            if (add_b_stb && !a_done) proto_bad <= proto_bad + 1;
        end
        if (rst) a_done <= 0;
        else if (add_a_stb && add_a_ack) a_done <= 1;
        else if (add_b_stb && add_b_ack) a_done <= 0;
        if (!rst && add_a_stb && add_a_ack) a_xfers <= a_xfers + 1;
        if (!rst && add_z_stb && add_z_ack) z_xfers <= z_xfers + 1;
        p_rst <= rst;
        p_a_stb <= add_a_stb; p_a_ack <= add_a_ack; p_a <= add_a;
        p_b_stb <= add_b_stb; p_b_ack <= add_b_ack; p_b <= add_b;
        p_s_stb <= sum_stb;   p_s_ack <= sum_ack;   p_s <= sum_data;
    end

    // ---------------- Checking ----------------
    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    // Called at a negedge; returns at the negedge after the transfer.
    task automatic send_elem(input logic [31:0] x, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        in_data = x; in_stb = 1'b1; n = 0;
        while (!in_ack && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) begin timeout("in_ack"); in_stb = 1'b0; return; end
        @(negedge clk);
        in_stb = 1'b0;
    endtask

    task automatic wait_sum(output logic ok);
        int n = 0;
        while (!sum_stb && n < 500) begin @(negedge clk); n++; end
        ok = sum_stb;
        if (!ok) timeout("sum_stb");
    endtask

    task automatic get_sum(input int dly, output logic [31:0] v);
        logic ok;
        wait_sum(ok);
        v = 'x;
        if (!ok) return;
        repeat (dly) @(negedge clk);
        v = sum_data; sum_ack = 1'b1;
        @(negedge clk);
        sum_ack = 1'b0;
    endtask

    typedef struct {
        logic [31:0] x[4];
        logic [31:0] sum;
        int          a_cnt;
        string       name;
    } vec_t;

    vec_t        tbl[4];
    logic [31:0] got;
    logic        ok;
    int          base, hold_bad, ref_sum, v, n;

    initial begin
        tbl[0] = '{'{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000}, 32'h41200000, 4, "sum_1234"};
        tbl[1] = '{'{32'h7F800000, 32'hFF800000, 32'h00000000, 32'h00000000}, 32'hFFC00000,
                   (SKIP != 0) ? 2 : 4, "inf_minus_inf"};
        tbl[2] = '{'{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000}, 32'h40800000, 4, "ones"};
        tbl[3] = '{'{32'h3F800000, 32'h00000000, 32'h80000000, 32'h3F800000}, 32'h40000000,
                   (SKIP != 0) ? 2 : 4, "sparse"};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ack", {31'b0, in_ack}, 0);
        chk("rst_a_stb", {31'b0, add_a_stb}, 0);
        chk("rst_b_stb", {31'b0, add_b_stb}, 0);
        chk("rst_z_ack", {31'b0, add_z_ack}, 0);
        chk("rst_sum_stb", {31'b0, sum_stb}, 0);
        chk("rst_sum_data", sum_data, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < 4; i++) begin
            base = a_xfers;
            for (int j = 0; j < 4; j++) send_elem(tbl[i].x[j], 0);
            get_sum(1, got);
            chk({tbl[i].name, "_sum"}, got, tbl[i].sum);
            chk({tbl[i].name, "_a_xfers"}, a_xfers - base, tbl[i].a_cnt);
        end

        // Back-to-back with sum_ack held off; next element offered during PUT_SUM
        for (int j = 0; j < 4; j++) send_elem(32'h3F800000, 0);
        wait_sum(ok);
        in_data = 32'h40000000; in_stb = 1'b1;
        hold_bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!(sum_stb && sum_data == 32'h40800000 && !in_ack)) hold_bad++;
        end
        chk("b2b_hold", hold_bad, 0);
        chk("b2b_first_sum", sum_data, 32'h40800000);
        sum_ack = 1'b1;
        @(negedge clk);
        sum_ack = 1'b0;
        chk("b2b_stb_drop", {31'b0, sum_stb}, 0);
        for (int j = 0; j < 4; j++) send_elem(32'h40000000, 0);
        get_sum(0, got);
        chk("b2b_second_sum", got, 32'h41000000);

        // Reset after the second element's result transfer
        base = z_xfers;
        send_elem(32'h40000000, 0);
        send_elem(32'h40000000, 0);
        n = 0;
        while (z_xfers < base + 2 && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) timeout("z_xfer");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", {31'b0, busy}, 0);
        base = a_xfers;
        for (int j = 0; j < 4; j++) send_elem(32'h3F800000, 1);
        get_sum(2, got);
        chk("midrst_sum", got, 32'h40800000);
        chk("midrst_a_xfers", a_xfers - base, 4);

        // Randomized vectors of small integers (exact in FP32) vs integer sum
        for (int t = 0; t < 300; t++) begin
            ref_sum = 0;
            for (int j = 0; j < VL; j++) begin
                v = int'($urandom_range(0, 2000)) - 1000;
                if ($urandom_range(0, 7) == 0) v = 0;
                ref_sum += v;
                send_elem(int2f(v), int'($urandom_range(0, 2)));
            end
            get_sum(int'($urandom_range(0, 3)), got);
            chk("rand_sum", got, int2f(ref_sum));
        end

        repeat (3) @(negedge clk);
        chk("protocol", proto_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
